// File: rtl/nanci_pkg.sv
// Shared definitions for the Nanci sort-mesh PE: op and state encodings plus
// width helpers used to size records and the neighbour-select field.
package nanci_pkg;

  // Step operation applied on every RUN cycle.
  typedef enum logic [1:0] {
    OP_HOLD  = 2'b00,
    OP_SHIFT = 2'b01,
    OP_MIN   = 2'b10,
    OP_MAX   = 2'b11
  } op_e;

  // Exchange engine control state.
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Record width: addr field in the MSBs, data field in the LSBs.
  function automatic int rec_w(input int addr_w, input int data_w);
    return addr_w + data_w;
  endfunction

  // Neighbour-select width, never narrower than one bit.
  function automatic int sel_w(input int n_ports);
    return (n_ports > 2) ? $clog2(n_ports) : 1;
  endfunction

endpackage

// File: rtl/pe_key_select.sv
// Combinational neighbour mux plus unsigned addr compare. Produces the record
// the PE should hold after one step of the given op. A select index with no
// matching channel leaves the record unchanged.
module pe_key_select
  import nanci_pkg::*;
#(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 3,
  parameter int N_PORTS    = 4,
  localparam int W         = rec_w(ADDR_WIDTH, DATA_WIDTH),
  localparam int SW        = sel_w(N_PORTS)
) (
  input  logic [1:0]           i_op,
  input  logic [SW-1:0]        i_sel,
  input  logic [W-1:0]         i_own,
  input  logic [N_PORTS*W-1:0] i_nbr,
  output logic [W-1:0]         o_next
);

  logic [W-1:0]          nb;
  logic                  nb_valid;
  logic [ADDR_WIDTH-1:0] nb_addr;
  logic [ADDR_WIDTH-1:0] own_addr;

  // Pick the selected neighbour record and decide the next record for the op.
  always_comb begin
    nb       = '0;
    nb_valid = 1'b0;
    for (int k = 0; k < N_PORTS; k++) begin
      nb       = (i_sel == k[SW-1:0]) ? i_nbr[k*W +: W] : nb;
      nb_valid = (i_sel == k[SW-1:0]) ? 1'b1 : nb_valid;
    end
    nb_addr  = nb[W-1 -: ADDR_WIDTH];
    own_addr = i_own[W-1 -: ADDR_WIDTH];
    o_next   = i_own;
    case (i_op)
      OP_HOLD: begin
        o_next = i_own;
      end
      OP_SHIFT: begin
        if (nb_valid) begin
          o_next = nb;
        end else begin
          o_next = i_own;
        end
      end
      OP_MIN: begin
        // Ties keep the own record; data never takes part in the compare.
        if (nb_valid && (nb_addr < own_addr)) begin
          o_next = nb;
        end else begin
          o_next = i_own;
        end
      end
      OP_MAX: begin
        if (nb_valid && (nb_addr > own_addr)) begin
          o_next = nb;
        end else begin
          o_next = i_own;
        end
      end
      default: begin
        o_next = i_own;
      end
    endcase
  end

endmodule

// File: rtl/pe_neighbor_exchange.sv
// Record-exchange engine for one PE of the Nanci sort mesh. Holds one
// {addr,data} record; a start launches STEPS steps of a latched op/select,
// each step taking the neighbour-derived record from pe_key_select.
module pe_neighbor_exchange
  import nanci_pkg::*;
#(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 3,
  parameter int N_PORTS    = 4,
  parameter int STEPS      = 1,
  parameter logic [ADDR_WIDTH+DATA_WIDTH-1:0] RST_VALUE = '0,
  localparam int W         = rec_w(ADDR_WIDTH, DATA_WIDTH),
  localparam int SW        = sel_w(N_PORTS),
  localparam int STW       = $clog2(STEPS + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_load,
  input  logic [W-1:0]         i_init,
  input  logic                 i_start,
  input  logic [1:0]           i_op,
  input  logic [SW-1:0]        i_sel,
  input  logic [N_PORTS*W-1:0] i_nbr,
  output logic [W-1:0]         o_PE,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [STW-1:0]       o_step
);

  localparam logic [STW-1:0] STEP_LAST = STW'(STEPS - 1);
  localparam logic [STW-1:0] STEP_MAX  = STW'(STEPS);

  state_e         state_q, state_d;
  logic [1:0]     op_q, op_d;
  logic [SW-1:0]  sel_q, sel_d;
  logic [W-1:0]   pe_q, pe_d;
  logic [STW-1:0] step_q, step_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [W-1:0]   next_rec;

  pe_key_select #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .N_PORTS    (N_PORTS)
  ) u_key_select (
    .i_op   (op_q),
    .i_sel  (sel_q),
    .i_own  (pe_q),
    .i_nbr  (i_nbr),
    .o_next (next_rec)
  );

  // Next-state, record and handshake logic; load has priority over start.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    sel_d   = sel_q;
    pe_d    = pe_q;
    step_d  = step_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_load) begin
          pe_d = i_init;
        end else if (i_start) begin
          state_d = ST_RUN;
          op_d    = i_op;
          sel_d   = i_sel;
          step_d  = '0;
          busy_d  = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        pe_d = next_rec;
        if (step_q == STEP_MAX) begin
          step_d = step_q;
        end else begin
          step_d = step_q + STW'(1);
        end
        if (step_q == STEP_LAST) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          busy_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset; reset aborts a run silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= OP_HOLD;
      sel_q   <= '0;
      pe_q    <= RST_VALUE;
      step_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      sel_q   <= sel_d;
      pe_q    <= pe_d;
      step_q  <= step_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign o_PE   = pe_q;
  assign o_busy = busy_q;
  assign o_done = done_q;
  assign o_step = step_q;

endmodule

// File: tb/tb_pe_neighbor_exchange.sv
// Bench for pe_neighbor_exchange: two instances (4 ports / 1 step and
// 5 ports / 4 steps) share stimulus; a behavioural model tracks each one and
// is compared every cycle, with directed literal checks for key scenarios.
module tb_pe_neighbor_exchange;

  logic        clk;
  logic        rst;
  logic        i_load;
  logic [5:0]  i_init;
  logic        i_start;
  logic [1:0]  i_op;
  logic [2:0]  i_sel;
  logic [29:0] i_nbr;

  logic [5:0]  u1_pe;
  logic        u1_busy, u1_done;
  logic [0:0]  u1_step;
  logic [5:0]  u4_pe;
  logic        u4_busy, u4_done;
  logic [2:0]  u4_step;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  int u4_done_cnt = 0;

  // behavioural model state per instance (0: u1, 1: u4)
  logic [5:0] m_pe   [2];
  bit         m_run  [2];
  bit         m_done [2];
  int         m_step [2];
  int         m_left [2];
  int         m_op   [2];
  int         m_sel  [2];

  pe_neighbor_exchange #(
    .ADDR_WIDTH(3), .DATA_WIDTH(3), .N_PORTS(4), .STEPS(1), .RST_VALUE(6'o00)
  ) u1 (
    .clk(clk), .rst(rst), .i_load(i_load), .i_init(i_init), .i_start(i_start),
    .i_op(i_op), .i_sel(i_sel[1:0]), .i_nbr(i_nbr[23:0]),
    .o_PE(u1_pe), .o_busy(u1_busy), .o_done(u1_done), .o_step(u1_step)
  );

  pe_neighbor_exchange #(
    .ADDR_WIDTH(3), .DATA_WIDTH(3), .N_PORTS(5), .STEPS(4), .RST_VALUE(6'o00)
  ) u4 (
    .clk(clk), .rst(rst), .i_load(i_load), .i_init(i_init), .i_start(i_start),
    .i_op(i_op), .i_sel(i_sel), .i_nbr(i_nbr),
    .o_PE(u4_pe), .o_busy(u4_busy), .o_done(u4_done), .o_step(u4_step)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int np_of(input int d);
    return (d == 0) ? 4 : 5;
  endfunction

  function automatic int steps_of(input int d);
    return (d == 0) ? 1 : 4;
  endfunction

  function automatic int smask_of(input int d);
    return (d == 0) ? 3 : 7;
  endfunction

  // Record after one step, straight from the op rules.
  function automatic logic [5:0] step_rec(input int op, input int sel, input int np,
                                          input logic [5:0] own, input logic [29:0] nbr);
    logic [5:0] nb;
    int na, oa;
    if (sel >= np) return own;
    nb = 6'(nbr >> (sel * 6));
    na = int'(nb) / 8;
    oa = int'(own) / 8;
    case (op)
      1: return nb;
      2: return (na < oa) ? nb : own;
      3: return (na > oa) ? nb : own;
      default: return own;
    endcase
  endfunction

  // Behavioural model advanced on each rising edge.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_pe[d]   <= 6'o00;
        m_run[d]  <= 1'b0;
        m_done[d] <= 1'b0;
        m_step[d] <= 0;
        m_left[d] <= 0;
        m_op[d]   <= 0;
        m_sel[d]  <= 0;
      end else begin
        m_done[d] <= 1'b0;
        if (!m_run[d]) begin
          if (i_load) begin
            m_pe[d] <= i_init;
          end else if (i_start) begin
            m_run[d]  <= 1'b1;
            m_op[d]   <= int'(i_op);
            m_sel[d]  <= int'(i_sel) & smask_of(d);
            m_step[d] <= 0;
            m_left[d] <= steps_of(d);
          end
        end else begin
          m_pe[d]   <= step_rec(m_op[d], m_sel[d], np_of(d), m_pe[d], i_nbr);
          m_step[d] <= m_step[d] + 1;
          m_left[d] <= m_left[d] - 1;
          if (m_left[d] == 1) begin
            m_run[d]  <= 1'b0;
            m_done[d] <= 1'b1;
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("u1_pe",   32'(u1_pe),   32'(m_pe[0]));
      chk("u1_busy", 32'(u1_busy), 32'(m_run[0]));
      chk("u1_done", 32'(u1_done), 32'(m_done[0]));
      chk("u1_step", 32'(u1_step), 32'(m_step[0]));
      chk("u4_pe",   32'(u4_pe),   32'(m_pe[1]));
      chk("u4_busy", 32'(u4_busy), 32'(m_run[1]));
      chk("u4_done", 32'(u4_done), 32'(m_done[1]));
      chk("u4_step", 32'(u4_step), 32'(m_step[1]));
    end
  end

  // Count completion pulses of the 4-step instance.
  always @(posedge clk) begin
    if (u4_done === 1'b1) u4_done_cnt <= u4_done_cnt + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_nbr(input int ch, input logic [5:0] v);
    i_nbr[ch*6 +: 6] = v;
  endtask

  task automatic do_load(input logic [5:0] v);
    i_load = 1'b1;
    i_init = v;
    cyc(1);
    i_load = 1'b0;
  endtask

  task automatic start_run(input logic [1:0] op, input logic [2:0] sel);
    i_op    = op;
    i_sel   = sel;
    i_start = 1'b1;
    cyc(1);
    i_start = 1'b0;
  endtask

  int cnt0;

  initial begin
    rst = 1'b1; i_load = 1'b0; i_init = 6'o00; i_start = 1'b0;
    i_op = 2'b00; i_sel = 3'd0; i_nbr = 30'd0;
    cyc(2);
    // reset state
    chk("rst_pe",   32'(u1_pe),   32'd0);
    chk("rst_busy", 32'(u1_busy), 32'd0);
    chk("rst_done", 32'(u1_done), 32'd0);
    chk("rst_step", 32'(u4_step), 32'd0);
    chk_en = 1'b1;
    rst = 1'b0;

    // single-step shift from the right channel
    set_nbr(0, 6'o01); set_nbr(1, 6'o02); set_nbr(2, 6'o03); set_nbr(3, 6'o04);
    start_run(2'b01, 3'd1);
    cyc(1);
    chk("shift_done", 32'(u1_done), 32'd1);
    chk("shift_pe",   32'(u1_pe),   32'(6'o02));
    chk("model_shift_pe", 32'(m_pe[0]), 32'(6'o02));
    cyc(6);

    // keep-min, keep-max and tie
    do_load(6'o53);
    set_nbr(0, 6'o27);
    start_run(2'b10, 3'd0);
    cyc(1);
    chk("min_pe", 32'(u1_pe), 32'(6'o27));
    cyc(6);
    do_load(6'o53);
    start_run(2'b11, 3'd0);
    cyc(1);
    chk("max_pe", 32'(u1_pe), 32'(6'o53));
    cyc(6);
    do_load(6'o53);
    set_nbr(0, 6'o51);
    start_run(2'b10, 3'd0);
    cyc(1);
    chk("tie_pe", 32'(u1_pe), 32'(6'o53));
    chk("model_tie_pe", 32'(m_pe[0]), 32'(6'o53));
    cyc(6);

    // four-step shift with a changing channel
    do_load(6'o00);
    cnt0 = u4_done_cnt;
    start_run(2'b01, 3'd3);
    for (int k = 1; k <= 4; k++) begin
      set_nbr(3, 6'(k));
      cyc(1);
      chk("multi_step", 32'(u4_step), 32'(k));
    end
    chk("multi_pe",   32'(u4_pe),   32'd4);
    chk("multi_done", 32'(u4_done), 32'd1);
    chk("multi_busy", 32'(u4_busy), 32'd0);
    cyc(2);
    chk("multi_done_cnt", 32'(u4_done_cnt - cnt0), 32'd1);
    cyc(2);

    // load and start together: load wins
    i_init = 6'o12; i_load = 1'b1; i_start = 1'b1; i_op = 2'b01;
    cyc(1);
    i_load = 1'b0; i_start = 1'b0;
    chk("ldst_pe",   32'(u1_pe),   32'(6'o12));
    chk("ldst_busy", 32'(u4_busy), 32'd0);
    // start during a run is ignored
    cnt0 = u4_done_cnt;
    start_run(2'b00, 3'd0);
    cyc(1);
    i_start = 1'b1;
    cyc(1);
    i_start = 1'b0;
    cyc(6);
    chk("ignore_start_done_cnt", 32'(u4_done_cnt - cnt0), 32'd1);

    // reset mid-run aborts with no done
    do_load(6'o35);
    set_nbr(2, 6'o44);
    start_run(2'b01, 3'd2);
    cyc(1);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    chk("abort_busy", 32'(u4_busy), 32'd0);
    chk("abort_pe",   32'(u4_pe),   32'd0);
    cnt0 = u4_done_cnt;
    cyc(6);
    chk("abort_no_done", 32'(u4_done_cnt - cnt0), 32'd0);

    // out-of-range select behaves as hold but the run completes
    do_load(6'o35);
    start_run(2'b01, 3'd7);
    for (int k = 0; k < 4; k++) begin
      i_nbr = 30'($urandom);
      cyc(1);
    end
    chk("sel7_done", 32'(u4_done), 32'd1);
    chk("sel7_pe",   32'(u4_pe),   32'(6'o35));
    cyc(2);

    // randomized traffic checked by the model
    for (int n = 0; n < 600; n++) begin
      i_load  = ($urandom_range(0, 7) == 0);
      i_start = ($urandom_range(0, 3) == 0);
      i_op    = 2'($urandom);
      i_sel   = 3'($urandom);
      i_init  = 6'($urandom);
      i_nbr   = 30'($urandom);
      rst     = ($urandom_range(0, 63) == 0);
      cyc(1);
    end
    rst = 1'b0; i_load = 1'b0; i_start = 1'b0;
    cyc(8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
